// File: rtl/net_packet_rx_pkg.sv
// Shared network packet definitions and core run-state encoding for the
// packet receiver and the core that consumes its write strobes.
package net_packet_rx_pkg;

  localparam int unsigned rs_imm_size_gp  = 6;
  localparam int unsigned mask_length_gp  = 3;
  localparam int unsigned net_id_width_gp = 10;
  localparam int unsigned net_addr_width_gp = 10;

  typedef enum logic [2:0] {
    NULL  = 3'd0,
    INSTR = 3'd1,
    REG   = 3'd2,
    BAR   = 3'd3,
    PC    = 3'd4
  } net_op_e;

  typedef struct packed {
    logic [net_id_width_gp-1:0]   ID;
    net_op_e                      net_op;
    logic [net_addr_width_gp-1:0] net_addr;
    logic [31:0]                  net_data;
  } net_packet_s;

  typedef enum logic {
    HALTED  = 1'b0,
    RUNNING = 1'b1
  } core_state_e;

  // True when no address bit at or above 'width' is set.
  function automatic logic addr_in_range(input logic [net_addr_width_gp-1:0] addr,
                                         input int unsigned width);
    return (addr >> width) == '0;
  endfunction

endpackage

// File: rtl/net_rx_sat_counter.sv
// Saturating up-counter: holds at all-ones, clears only on reset.
module net_rx_sat_counter #(
  parameter int unsigned width_p = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_en,
  output logic [width_p-1:0] o_count
);

  logic [width_p-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset)
      r_count <= '0;
    else if (i_en && (r_count != '1))
      r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;

endmodule

// File: rtl/net_packet_rx.sv
// Network-side packet receiver: registers each packet, decodes it one cycle
// later into registered write strobes, and owns the core halted/running state.
module net_packet_rx
  import net_packet_rx_pkg::*;
#(
  parameter logic [9:0]  id_p              = 10'd1,
  parameter int unsigned imem_addr_width_p = 10,
  parameter int unsigned rf_addr_width_p   = rs_imm_size_gp,
  parameter int unsigned mask_width_p      = mask_length_gp
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [$bits(net_packet_s)-1:0] net_packet_flat_i,
  input  logic                         exception_i,
  output logic                         imem_wen_o,
  output logic [imem_addr_width_p-1:0] imem_addr_o,
  output logic [15:0]                  imem_data_o,
  output logic                         rf_wen_o,
  output logic [rf_addr_width_p-1:0]   rf_addr_o,
  output logic [31:0]                  rf_data_o,
  output logic [mask_width_p-1:0]      barrier_mask_o,
  output logic                         pc_wen_o,
  output logic [imem_addr_width_p-1:0] pc_o,
  output logic                         run_o,
  output logic [imem_addr_width_p:0]   instr_count_o,
  output logic [rf_addr_width_p:0]     reg_count_o,
  output logic                         err_o
);

  net_packet_s                  r_pkt;
  core_state_e                  r_state;
  logic                         r_imem_wen;
  logic [imem_addr_width_p-1:0] r_imem_addr;
  logic [15:0]                  r_imem_data;
  logic                         r_rf_wen;
  logic [rf_addr_width_p-1:0]   r_rf_addr;
  logic [31:0]                  r_rf_data;
  logic [mask_width_p-1:0]      r_mask;
  logic                         r_pc_wen;
  logic [imem_addr_width_p-1:0] r_pc;
  logic                         r_err;

  logic w_instr_ok, w_reg_ok, w_bar, w_pc, w_err;

  always_comb begin
    w_instr_ok = 1'b0;
    w_reg_ok   = 1'b0;
    w_bar      = 1'b0;
    w_pc       = 1'b0;
    w_err      = 1'b0;
    if (r_pkt.ID == id_p) begin
      case (r_pkt.net_op)
        NULL:  ;
        INSTR: if (r_state == HALTED && addr_in_range(r_pkt.net_addr, imem_addr_width_p))
                 w_instr_ok = 1'b1;
               else
                 w_err = 1'b1;
        REG:   if (r_state == HALTED && addr_in_range(r_pkt.net_addr, rf_addr_width_p))
                 w_reg_ok = 1'b1;
               else
                 w_err = 1'b1;
        BAR:   w_bar = 1'b1;
        PC:    w_pc  = 1'b1;
        default: w_err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pkt       <= '0;
      r_state     <= HALTED;
      r_imem_wen  <= 1'b0;
      r_imem_addr <= '0;
      r_imem_data <= '0;
      r_rf_wen    <= 1'b0;
      r_rf_addr   <= '0;
      r_rf_data   <= '0;
      r_mask      <= '0;
      r_pc_wen    <= 1'b0;
      r_pc        <= '0;
      r_err       <= 1'b0;
    end else begin
      r_pkt      <= net_packet_flat_i;
      r_imem_wen <= w_instr_ok;
      r_rf_wen   <= w_reg_ok;
      r_pc_wen   <= w_pc;
      r_err      <= r_err | w_err;
      if (w_instr_ok) begin
        r_imem_addr <= r_pkt.net_addr[imem_addr_width_p-1:0];
        r_imem_data <= r_pkt.net_data[15:0];
      end
      if (w_reg_ok) begin
        r_rf_addr <= r_pkt.net_addr[rf_addr_width_p-1:0];
        r_rf_data <= r_pkt.net_data;
      end
      if (w_bar)
        r_mask <= r_pkt.net_data[mask_width_p-1:0];
      if (w_pc)
        r_pc <= r_pkt.net_addr[imem_addr_width_p-1:0];
      // A PC load in the same decode cycle as an exception keeps the core running.
      if (w_pc)
        r_state <= RUNNING;
      else if (exception_i && r_state == RUNNING)
        r_state <= HALTED;
    end
  end

  net_rx_sat_counter #(.width_p(imem_addr_width_p + 1)) u_instr_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_instr_ok),
    .o_count (instr_count_o)
  );

  net_rx_sat_counter #(.width_p(rf_addr_width_p + 1)) u_reg_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_reg_ok),
    .o_count (reg_count_o)
  );

  assign imem_wen_o     = r_imem_wen;
  assign imem_addr_o    = r_imem_addr;
  assign imem_data_o    = r_imem_data;
  assign rf_wen_o       = r_rf_wen;
  assign rf_addr_o      = r_rf_addr;
  assign rf_data_o      = r_rf_data;
  assign barrier_mask_o = r_mask;
  assign pc_wen_o       = r_pc_wen;
  assign pc_o           = r_pc;
  assign run_o          = (r_state == RUNNING);
  assign err_o          = r_err;

endmodule
